// File: rtl/jesd204_fec_pkg.sv
// Shared JESD204C FEC definitions: code geometry, generator taps and parity bit order.
// Used by both the TX encoder and the RX decoder.
package jesd204_fec_pkg;

    localparam int unsigned FEC_WIDTH    = 26;
    localparam int unsigned BLOCK_LENGTH = 2048;

    typedef logic [FEC_WIDTH-1:0] fec_t;

    // g(x) = x^26 + x^21 + x^17 + x^9 + x^4 + 1, x^26 term implied
    localparam fec_t FEC_POLY = 26'h0220211;

    // fec[i] is the coefficient of x^i; fec[FEC_WIDTH-1] goes on the wire first
    localparam int unsigned FEC_FIRST_BIT = FEC_WIDTH - 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fec_state_e;

    typedef struct packed {
        fec_t parity;
        logic valid;
        logic err;
    } fec_result_t;

    // One bit of the parity-form divider: the input bit joins the feedback term
    function automatic fec_t fec_step(fec_t r, logic b);
        logic fb;
        fb = b ^ r[FEC_WIDTH-1];
        return {r[FEC_WIDTH-2:0], 1'b0} ^ (fb ? FEC_POLY : fec_t'(0));
    endfunction

    // k-th parity bit in transmit order
    function automatic logic fec_tx_bit(fec_t f, logic [4:0] k);
        return f[5'(FEC_FIRST_BIT) - k];
    endfunction

endpackage

// File: rtl/jesd204_tx_fec_lfsr.sv
// Parallel FEC remainder register: SHIFT_WIDTH bits per cycle, bit 0 first in time.
// next_c is the remainder including the current beat, available combinationally.
module jesd204_tx_fec_lfsr
    import jesd204_fec_pkg::*;
#(
    parameter int unsigned SHIFT_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   clear,
    input  logic                   shift,
    input  logic [SHIFT_WIDTH-1:0] data,
    output fec_t                   next_c
);

    fec_t state_q;

    // Unrolled bit-serial division over the whole beat
    always_comb begin
        fec_t r;
        r = state_q;
        for (int i = 0; i < int'(SHIFT_WIDTH); i++) begin
            r = fec_step(r, data[i]);
        end
        next_c = r;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= '0;
        end else if (clear) begin
            state_q <= '0;
        end else if (shift) begin
            state_q <= next_c;
        end
    end

endmodule

// File: rtl/jesd204_fec_encode.sv
// JESD204C TX FEC encoder: 26-bit parity per 2048-bit multiblock, presented during
// the following multiblock; payload passes through with one cycle of latency.
module jesd204_fec_encode
    import jesd204_fec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  eomb,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [FEC_WIDTH-1:0]  fec_out,
    output logic                  fec_out_valid,
    output logic                  block_err
);

    localparam int unsigned BLOCK_CYCLE_CNT = BLOCK_LENGTH / DATA_WIDTH;
    localparam int unsigned CNT_WIDTH       = $clog2(BLOCK_CYCLE_CNT);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BLOCK_CYCLE_CNT - 1);

    fec_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovr_q, ovr_d;
    fec_result_t          res_q, res_d;
    logic [DATA_WIDTH-1:0] data_q;

    logic lfsr_clear_c;
    logic lfsr_shift_c;
    fec_t lfsr_next_c;

    jesd204_tx_fec_lfsr #(
        .SHIFT_WIDTH (DATA_WIDTH)
    ) u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .clear  (lfsr_clear_c),
        .shift  (lfsr_shift_c),
        .data   (data_in),
        .next_c (lfsr_next_c)
    );

    // Alignment, block sizing and parity hand-off
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ovr_d        = ovr_q;
        lfsr_clear_c = 1'b0;
        lfsr_shift_c = 1'b0;
        res_d        = res_q;
        res_d.valid  = 1'b0;
        res_d.err    = 1'b0;

        if (!enable) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            ovr_d        = 1'b0;
            lfsr_clear_c = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Partial block before the first eomb is discarded
                    cnt_d        = '0;
                    ovr_d        = 1'b0;
                    lfsr_clear_c = 1'b1;
                    if (eomb) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (eomb) begin
                        cnt_d        = '0;
                        ovr_d        = 1'b0;
                        lfsr_clear_c = 1'b1;
                        if (cnt_q == CNT_LAST && !ovr_q) begin
                            res_d.parity = lfsr_next_c;
                            res_d.valid  = 1'b1;
                        end else begin
                            res_d.err = 1'b1;
                        end
                    end else begin
                        lfsr_shift_c = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            ovr_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            res_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            res_q   <= res_d;
            data_q  <= data_in;
        end
    end

    assign data_out      = data_q;
    assign fec_out       = res_q.parity;
    assign fec_out_valid = res_q.valid;
    assign block_err     = res_q.err;

endmodule

// File: tb/tb_jesd204_fec_encode.sv
// Directed and randomised checks of the JESD204C TX FEC encoder at DATA_WIDTH=64.
module tb_jesd204_fec_encode;

    localparam int unsigned W     = 64;
    localparam int unsigned BL    = 2048;
    localparam int unsigned BEATS = BL / W;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enable;
    logic          eomb;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic [25:0]   fec_out;
    logic          fec_out_valid;
    logic          block_err;

    int vectors     = 0;
    int miscompares = 0;
    int stray       = 0;
    int dout_err    = 0;

    jesd204_fec_encode #(.DATA_WIDTH(W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .eomb          (eomb),
        .data_in       (data_in),
        .data_out      (data_out),
        .fec_out       (fec_out),
        .fec_out_valid (fec_out_valid),
        .block_err     (block_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Classic long division of M(x)*x^26 by g(x), bit 0 of blk first in time
    function automatic logic [25:0] ref_parity(input logic [BL-1:0] blk);
        logic [26:0] r;
        logic        b;
        r = '0;
        for (int j = 0; j < int'(BL) + 26; j++) begin
            b = (j < int'(BL)) ? blk[j] : 1'b0;
            r = {r[25:0], b};
            if (r[26]) r = r ^ 27'h4220211;
        end
        return r[25:0];
    endfunction

    function automatic logic [BL-1:0] one_bit(input int pos);
        logic [BL-1:0] blk;
        blk = '0;
        blk[pos] = 1'b1;
        return blk;
    endfunction

    // One beat; outputs sampled 1 time unit after the capturing edge
    task automatic drive(input logic [W-1:0] d, input logic e);
        data_in = d;
        eomb    = e;
        @(posedge clk);
        #1;
        if (data_out !== d) dout_err++;
    endtask

    task automatic send_block(input logic [BL-1:0] blk, input int nbeats, input logic with_eomb);
        for (int b = 0; b < nbeats; b++) begin
            drive(blk[(b % int'(BEATS)) * int'(W) +: W], with_eomb && (b == nbeats - 1));
            if (b != nbeats - 1 && (fec_out_valid || block_err)) stray++;
        end
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        enable  = 1'b0;
        eomb    = 1'b1;
        data_in = '1;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (data_out !== '0) begin miscompares++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        vectors++; if (fec_out !== 26'h0) begin miscompares++; $display("FAIL reset_fec_out: got %h want 0", fec_out); end
        vectors++; if (fec_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", fec_out_valid); end
        vectors++; if (block_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", block_err); end
        resetn = 1'b1;
        enable = 1'b1;
        eomb   = 1'b0;
    endtask

    task automatic test_align();
        drive('0, 1'b1);
        vectors++; if (fec_out_valid !== 1'b0 || block_err !== 1'b0) begin
            miscompares++; $display("FAIL idle_eomb_pulse: got valid=%b err=%b want 0/0", fec_out_valid, block_err);
        end
    endtask

    task automatic test_zero_blocks();
        stray = 0;
        for (int n = 0; n < 3; n++) begin
            send_block('0, BEATS, 1'b1);
            vectors++; if (fec_out_valid !== 1'b1 || block_err !== 1'b0 || fec_out !== 26'h0) begin
                miscompares++; $display("FAIL zero_block%0d: got valid=%b err=%b fec=%h want 1/0/0000000", n, fec_out_valid, block_err, fec_out);
            end
        end
        vectors++; if (stray !== 0) begin miscompares++; $display("FAIL zero_stray_pulses: got %0d want 0", stray); end
    endtask

    task automatic test_single_bit();
        int          pos [3];
        logic [25:0] exp [3];
        pos = '{2047, 2046, 2043};
        exp = '{26'h0220211, 26'h0440422, 26'h2202110};
        for (int k = 0; k < 3; k++) begin
            send_block(one_bit(pos[k]), BEATS, 1'b1);
            vectors++; if (fec_out_valid !== 1'b1 || fec_out !== exp[k]) begin
                miscompares++; $display("FAIL single_bit%0d: got valid=%b fec=%h want 1/%h", pos[k], fec_out_valid, fec_out, exp[k]);
            end
        end
    endtask

    task automatic test_linearity();
        send_block(one_bit(2047) | one_bit(2046), BEATS, 1'b1);
        vectors++; if (fec_out_valid !== 1'b1 || fec_out !== 26'h0660633) begin
            miscompares++; $display("FAIL linearity: got valid=%b fec=%h want 1/0660633", fec_out_valid, fec_out);
        end
    endtask

    task automatic test_block_err();
        send_block('1, 10, 1'b1);
        vectors++; if (block_err !== 1'b1 || fec_out_valid !== 1'b0 || fec_out !== 26'h0660633) begin
            miscompares++; $display("FAIL short10: got err=%b valid=%b fec=%h want 1/0/0660633", block_err, fec_out_valid, fec_out);
        end
        send_block(one_bit(2047), BEATS, 1'b1);
        vectors++; if (fec_out_valid !== 1'b1 || block_err !== 1'b0 || fec_out !== 26'h0220211) begin
            miscompares++; $display("FAIL after_short: got valid=%b err=%b fec=%h want 1/0/0220211", fec_out_valid, block_err, fec_out);
        end
        send_block('0, BEATS - 1, 1'b1);
        vectors++; if (block_err !== 1'b1 || fec_out_valid !== 1'b0 || fec_out !== 26'h0220211) begin
            miscompares++; $display("FAIL short31: got err=%b valid=%b fec=%h want 1/0/0220211", block_err, fec_out_valid, fec_out);
        end
        send_block('0, BEATS + 2, 1'b1);
        vectors++; if (block_err !== 1'b1 || fec_out_valid !== 1'b0 || fec_out !== 26'h0220211) begin
            miscompares++; $display("FAIL long34: got err=%b valid=%b fec=%h want 1/0/0220211", block_err, fec_out_valid, fec_out);
        end
        send_block(one_bit(2046), BEATS, 1'b1);
        vectors++; if (fec_out_valid !== 1'b1 || block_err !== 1'b0 || fec_out !== 26'h0440422) begin
            miscompares++; $display("FAIL after_overrun: got valid=%b err=%b fec=%h want 1/0/0440422", fec_out_valid, block_err, fec_out);
        end
    endtask

    task automatic test_enable_drop();
        stray = 0;
        send_block('1, 10, 1'b0);
        enable = 1'b0;
        drive('1, 1'b0);
        drive('1, 1'b1);
        drive('1, 1'b0);
        vectors++; if (fec_out_valid !== 1'b0 || block_err !== 1'b0 || fec_out !== 26'h0440422) begin
            miscompares++; $display("FAIL enable_drop: got valid=%b err=%b fec=%h want 0/0/0440422", fec_out_valid, block_err, fec_out);
        end
        enable = 1'b1;
        send_block(one_bit(2047), BEATS, 1'b1);
        vectors++; if (fec_out_valid !== 1'b0 || block_err !== 1'b0 || fec_out !== 26'h0440422) begin
            miscompares++; $display("FAIL realign_no_pulse: got valid=%b err=%b fec=%h want 0/0/0440422", fec_out_valid, block_err, fec_out);
        end
        send_block(one_bit(2047), BEATS, 1'b1);
        vectors++; if (fec_out_valid !== 1'b1 || fec_out !== 26'h0220211) begin
            miscompares++; $display("FAIL after_enable: got valid=%b fec=%h want 1/0220211", fec_out_valid, fec_out);
        end
        vectors++; if (stray !== 0) begin miscompares++; $display("FAIL enable_stray_pulses: got %0d want 0", stray); end
    endtask

    task automatic test_reset_mid();
        send_block('1, 10, 1'b0);
        resetn = 1'b0;
        #1;
        vectors++; if (fec_out !== 26'h0 || fec_out_valid !== 1'b0 || block_err !== 1'b0 || data_out !== '0) begin
            miscompares++; $display("FAIL reset_mid: got fec=%h valid=%b err=%b dout=%h want 0", fec_out, fec_out_valid, block_err, data_out);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        send_block('0, BEATS, 1'b1);
        vectors++; if (fec_out_valid !== 1'b0 || block_err !== 1'b0 || fec_out !== 26'h0) begin
            miscompares++; $display("FAIL reset_realign: got valid=%b err=%b fec=%h want 0/0/0", fec_out_valid, block_err, fec_out);
        end
        send_block(one_bit(2046), BEATS, 1'b1);
        vectors++; if (fec_out_valid !== 1'b1 || fec_out !== 26'h0440422) begin
            miscompares++; $display("FAIL after_reset: got valid=%b fec=%h want 1/0440422", fec_out_valid, fec_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [BL-1:0] blk;
        logic [25:0]   exp;
        stray    = 0;
        dout_err = 0;
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < int'(BL) / 32; k++) blk[k*32 +: 32] = $urandom();
            exp = ref_parity(blk);
            send_block(blk, BEATS, 1'b1);
            vectors++; if (fec_out_valid !== 1'b1 || block_err !== 1'b0 || fec_out !== exp) begin
                miscompares++; $display("FAIL random_block%0d: got valid=%b err=%b fec=%h want 1/0/%h", n, fec_out_valid, block_err, fec_out, exp);
            end
        end
        vectors++; if (stray !== 0) begin miscompares++; $display("FAIL random_stray_pulses: got %0d want 0", stray); end
        vectors++; if (dout_err !== 0) begin miscompares++; $display("FAIL data_out_latency: got %0d bad beats want 0", dout_err); end
    endtask

    initial begin
        test_reset();
        test_align();
        test_zero_blocks();
        test_single_bit();
        test_linearity();
        test_block_err();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
